mmu_dummy_responder: RTL and testbench
======================================

Name: mmu_dummy_responder

Overview:
- Core-side responder of the MMU request/response FIFO interface, used in the dummy (FIFO-mode) MMU build.
- Pops alloc and free requests from the request FIFOs, arbitrates between them round-robin, and validates each request.
- Runs a simple aligned bump (ring) page allocator with a used-page counter.
- Writes exactly one response per popped request into the matching response FIFO.

Parameters:
- REQ_ID_W, 13, request id width
- PAGE_IDX_W, 15, page index width
- SIZE_W, 4, page-count field width
- REASON_W, 3, fail-reason width
- TOTAL_PAGES, 32768, managed pages; must be a multiple of 8 and <= 2^PAGE_IDX_W

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_req_fifo_empty  in  1  alloc request FIFO empty
- alloc_req_pop  out  1  pop alloc request; data valid the following cycle
- alloc_req_id  in  REQ_ID_W  popped request id
- alloc_req_page_count  in  SIZE_W  popped page count
- free_req_fifo_empty  in  1  free request FIFO empty
- free_req_pop  out  1  pop free request; data valid the following cycle
- free_req_id  in  REQ_ID_W  popped request id
- free_req_page_idx  in  PAGE_IDX_W  page index to free
- free_req_page_count  in  SIZE_W  page count to free
- alloc_rsp_fifo_full  in  1  alloc response FIFO full
- alloc_rsp_write_en  out  1  alloc response write strobe
- alloc_rsp_id / alloc_rsp_page_idx / alloc_rsp_fail / alloc_rsp_fail_reason  out  REQ_ID_W/PAGE_IDX_W/1/REASON_W  alloc response fields
- free_rsp_fifo_full  in  1  free response FIFO full
- free_rsp_write_en  out  1  free response write strobe
- free_rsp_id / free_rsp_fail / free_rsp_fail_reason  out  REQ_ID_W/1/REASON_W  free response fields
- used_page_count  out  PAGE_IDX_W+1  pages currently allocated
- busy  out  1  state != IDLE

Behaviour:
- Reset: every output 0, state IDLE, alloc_ptr 0, used 0, last_served = FREE (alloc wins first tie).
- FSM states: IDLE -> LATCH -> RESP -> IDLE. Throughput is one request per 3 cycles; at most one request is outstanding.
- IDLE, eligibility: alloc is eligible when !alloc_req_fifo_empty && !alloc_rsp_fifo_full; free is eligible likewise with its own flags.
- IDLE, selection: if both are eligible, serve the one opposite to last_served. Assert the selected pop for exactly one cycle, record the type, go to LATCH. If neither is eligible, stay in IDLE.
- LATCH: register the request fields presented by the FIFO; go to RESP.
- RESP: assert the matching write_en for one cycle with the response fields registered; update alloc_ptr and used; go to IDLE. Response-FIFO space is guaranteed by the check made in IDLE.
- Size rounding: 1->1, 2->2, 3..4->4, 5..8->8. A count of 0 or >8 fails with reason 1 (SIZE_INVALID).
- Alloc: aligned = round_up(alloc_ptr, size); if aligned+size > TOTAL_PAGES then aligned = 0 (wrap).
- Alloc out of memory: if used+size > TOTAL_PAGES, fail with reason 2 (NO_MEM); alloc_ptr and used are unchanged.
- Alloc success: page_idx = aligned; alloc_ptr <= aligned+size, or 0 if that equals TOTAL_PAGES; used += size.
- Free checks, in priority order: size invalid -> 1; idx+size > TOTAL_PAGES -> 3 (IDX_RANGE); idx not a multiple of size -> 4 (MISALIGNED); used < size -> 5 (UNDERFLOW). Otherwise success with used -= size.
- Fail responses: fail=1, page_idx=0, id echoed. Success responses: fail=0, reason=0.
- Use extended-width arithmetic so that the idx+size and used+size comparisons never overflow.
- Reset asserted mid-operation aborts the operation immediately. A request already popped is dropped without a response, and no write_en is issued after reset.
- Both response-full flags high: remain in IDLE and issue no pops.

Decomposition:
- Package mmu_resp_pkg holds: reason codes (NONE=0, SIZE_INVALID=1, NO_MEM=2, IDX_RANGE=3, MISALIGNED=4, UNDERFLOW=5), FSM state encoding, request-type encoding, and the width constants.
- One sub-module, mmu_size_align: combinational count -> {size, valid} rounding, instantiated once and shared by both the alloc and free paths.

Test Plan:
- Alloc count 3, id 0x10, after reset -> pop, then write_en 2 cycles later; rsp id 0x10, idx 0, fail 0; used=4.
- Alloc 1 (id 1), then alloc 8 (id 2) -> idx 0 and idx 8; used=9; alloc_ptr=16.
- Alloc and free FIFOs both non-empty from reset -> alloc served first, then free, alternating.
- Free idx 6 count 4 -> fail, reason 4. Free idx 32766 count 4 -> fail, reason 3. Free with used=0 -> fail, reason 5.
- Fill to used=TOTAL_PAGES-4, then alloc 8 -> fail, reason 2, used unchanged. Separately, alloc_ptr=32764 and alloc 8 -> wraps to idx 0.
- alloc_rsp_fifo_full held high -> no alloc pop, frees still served. Separately, rst asserted in LATCH -> no write_en, and used=0 next cycle.

Source files
------------

// File: rtl/mmu_resp_pkg.sv
// Shared types and default widths for the dummy MMU responder: fail reason
// codes, FSM state encoding, request type encoding.
package mmu_resp_pkg;

    localparam int MMU_REQ_ID_W    = 13;
    localparam int MMU_PAGE_IDX_W  = 15;
    localparam int MMU_SIZE_W      = 4;
    localparam int MMU_REASON_W    = 3;
    localparam int MMU_TOTAL_PAGES = 32768;

    typedef enum logic [2:0] {
        REASON_NONE         = 3'd0,
        REASON_SIZE_INVALID = 3'd1,
        REASON_NO_MEM       = 3'd2,
        REASON_IDX_RANGE    = 3'd3,
        REASON_MISALIGNED   = 3'd4,
        REASON_UNDERFLOW    = 3'd5
    } fail_reason_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef enum logic {
        REQ_ALLOC = 1'b0,
        REQ_FREE  = 1'b1
    } req_type_e;

endpackage

// File: rtl/mmu_size_align.sv
// Rounds a requested page count up to the power-of-two block size used by the
// allocator (1, 2, 4 or 8); any other count is flagged invalid with size 0.
module mmu_size_align
    import mmu_resp_pkg::*;
#(
    parameter int SIZE_W = MMU_SIZE_W
) (
    input  logic [SIZE_W-1:0] i_count,
    output logic [SIZE_W-1:0] o_size,
    output logic              o_valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_size  = '0;
        o_valid = 1'b0;
        if (i_count == SIZE_W'(1)) begin
            o_size  = SIZE_W'(1);
            o_valid = 1'b1;
        end else if (i_count == SIZE_W'(2)) begin
            o_size  = SIZE_W'(2);
            o_valid = 1'b1;
        end else if (i_count >= SIZE_W'(3) && i_count <= SIZE_W'(4)) begin
            o_size  = SIZE_W'(4);
            o_valid = 1'b1;
        end else if (i_count >= SIZE_W'(5) && i_count <= SIZE_W'(8)) begin
            o_size  = SIZE_W'(8);
            o_valid = 1'b1;
        end
    end

endmodule

// File: rtl/mmu_dummy_responder.sv
// Core-side responder for the FIFO-mode MMU: pops alloc/free requests
// round-robin, runs an aligned ring allocator, writes one response per request.
module mmu_dummy_responder
    import mmu_resp_pkg::*;
#(
    parameter int REQ_ID_W    = MMU_REQ_ID_W,
    parameter int PAGE_IDX_W  = MMU_PAGE_IDX_W,
    parameter int SIZE_W      = MMU_SIZE_W,
    parameter int REASON_W    = MMU_REASON_W,
    parameter int TOTAL_PAGES = MMU_TOTAL_PAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req_fifo_empty,
    output logic                  alloc_req_pop,
    input  logic [REQ_ID_W-1:0]   alloc_req_id,
    input  logic [SIZE_W-1:0]     alloc_req_page_count,
    input  logic                  free_req_fifo_empty,
    output logic                  free_req_pop,
    input  logic [REQ_ID_W-1:0]   free_req_id,
    input  logic [PAGE_IDX_W-1:0] free_req_page_idx,
    input  logic [SIZE_W-1:0]     free_req_page_count,
    input  logic                  alloc_rsp_fifo_full,
    output logic                  alloc_rsp_write_en,
    output logic [REQ_ID_W-1:0]   alloc_rsp_id,
    output logic [PAGE_IDX_W-1:0] alloc_rsp_page_idx,
    output logic                  alloc_rsp_fail,
    output logic [REASON_W-1:0]   alloc_rsp_fail_reason,
    input  logic                  free_rsp_fifo_full,
    output logic                  free_rsp_write_en,
    output logic [REQ_ID_W-1:0]   free_rsp_id,
    output logic                  free_rsp_fail,
    output logic [REASON_W-1:0]   free_rsp_fail_reason,
    output logic [PAGE_IDX_W:0]   used_page_count,
    output logic                  busy
);

    // Two spare bits keep idx+size, used+size and round-up free of overflow.
    localparam int EXT_W = PAGE_IDX_W + 2;
    localparam int CNT_W = PAGE_IDX_W + 1;
    localparam logic [EXT_W-1:0] TOTAL_EXT = EXT_W'(TOTAL_PAGES);

    state_e                r_state;
    req_type_e             r_type;
    req_type_e             r_last_served;
    logic [CNT_W-1:0]      r_alloc_ptr;
    logic [CNT_W-1:0]      r_used;
    logic                  r_alloc_req_pop;
    logic                  r_free_req_pop;
    logic                  r_alloc_rsp_write_en;
    logic [REQ_ID_W-1:0]   r_alloc_rsp_id;
    logic [PAGE_IDX_W-1:0] r_alloc_rsp_page_idx;
    logic                  r_alloc_rsp_fail;
    logic [REASON_W-1:0]   r_alloc_rsp_fail_reason;
    logic                  r_free_rsp_write_en;
    logic [REQ_ID_W-1:0]   r_free_rsp_id;
    logic                  r_free_rsp_fail;
    logic [REASON_W-1:0]   r_free_rsp_fail_reason;

    logic                  w_alloc_elig;
    logic                  w_free_elig;
    logic                  w_pick_alloc;
    logic [SIZE_W-1:0]     w_req_count;
    logic [SIZE_W-1:0]     w_size;
    logic                  w_size_valid;
    logic [EXT_W-1:0]      w_size_ext;
    logic [EXT_W-1:0]      w_size_mask;
    logic [EXT_W-1:0]      w_used_ext;
    logic [EXT_W-1:0]      w_ptr_round;
    logic [EXT_W-1:0]      w_alloc_base;
    logic [EXT_W-1:0]      w_alloc_end;
    logic [EXT_W-1:0]      w_free_idx_ext;
    logic                  w_no_mem;
    logic                  w_idx_range;
    logic                  w_misaligned;
    logic                  w_underflow;
    fail_reason_e          w_alloc_reason;
    fail_reason_e          w_free_reason;

    assign w_alloc_elig = !alloc_req_fifo_empty && !alloc_rsp_fifo_full;
    assign w_free_elig  = !free_req_fifo_empty && !free_rsp_fifo_full;
    assign w_pick_alloc = w_alloc_elig && (!w_free_elig || r_last_served == REQ_FREE);

    // Only one request is in flight, so a single rounding unit serves both paths.
    assign w_req_count = (r_type == REQ_FREE) ? free_req_page_count : alloc_req_page_count;

    mmu_size_align #(
        .SIZE_W (SIZE_W)
    ) u_size_align (
        .i_count (w_req_count),
        .o_size  (w_size),
        .o_valid (w_size_valid)
    );

    assign w_size_ext     = EXT_W'(w_size);
    assign w_size_mask    = w_size_ext - EXT_W'(1);
    assign w_used_ext     = EXT_W'(r_used);
    assign w_ptr_round    = (EXT_W'(r_alloc_ptr) + w_size_mask) & ~w_size_mask;
    assign w_alloc_base   = (w_ptr_round + w_size_ext > TOTAL_EXT) ? '0 : w_ptr_round;
    assign w_alloc_end    = w_alloc_base + w_size_ext;
    assign w_no_mem       = (w_used_ext + w_size_ext) > TOTAL_EXT;
    assign w_free_idx_ext = EXT_W'(free_req_page_idx);
    assign w_idx_range    = (w_free_idx_ext + w_size_ext) > TOTAL_EXT;
    assign w_misaligned   = |(w_free_idx_ext & w_size_mask);
    assign w_underflow    = w_used_ext < w_size_ext;

    always_comb begin
        w_alloc_reason = REASON_NONE;
        if (!w_size_valid)  w_alloc_reason = REASON_SIZE_INVALID;
        else if (w_no_mem)  w_alloc_reason = REASON_NO_MEM;
    end

    always_comb begin
        w_free_reason = REASON_NONE;
        if (!w_size_valid)      w_free_reason = REASON_SIZE_INVALID;
        else if (w_idx_range)   w_free_reason = REASON_IDX_RANGE;
        else if (w_misaligned)  w_free_reason = REASON_MISALIGNED;
        else if (w_underflow)   w_free_reason = REASON_UNDERFLOW;
    end

    // Pop is registered and high during LATCH; the popped fields are on the
    // request bus one cycle later, in RESP, where they are consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state                 <= ST_IDLE;
            r_type                  <= REQ_ALLOC;
            r_last_served           <= REQ_FREE;
            r_alloc_ptr             <= '0;
            r_used                  <= '0;
            r_alloc_req_pop         <= 1'b0;
            r_free_req_pop          <= 1'b0;
            r_alloc_rsp_write_en    <= 1'b0;
            r_alloc_rsp_id          <= '0;
            r_alloc_rsp_page_idx    <= '0;
            r_alloc_rsp_fail        <= 1'b0;
            r_alloc_rsp_fail_reason <= '0;
            r_free_rsp_write_en     <= 1'b0;
            r_free_rsp_id           <= '0;
            r_free_rsp_fail         <= 1'b0;
            r_free_rsp_fail_reason  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_alloc_req_pop      <= 1'b0;
            r_free_req_pop       <= 1'b0;
            r_alloc_rsp_write_en <= 1'b0;
            r_free_rsp_write_en  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_alloc_elig || w_free_elig) begin
                        if (w_pick_alloc) begin
                            r_alloc_req_pop <= 1'b1;
                            r_type          <= REQ_ALLOC;
                            r_last_served   <= REQ_ALLOC;
                        end else begin
                            r_free_req_pop  <= 1'b1;
                            r_type          <= REQ_FREE;
                            r_last_served   <= REQ_FREE;
                        end
                        r_state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (r_type == REQ_ALLOC) begin
                        r_alloc_rsp_write_en <= 1'b1;
                        r_alloc_rsp_id       <= alloc_req_id;
                        if (w_alloc_reason != REASON_NONE) begin
                            r_alloc_rsp_fail        <= 1'b1;
                            r_alloc_rsp_page_idx    <= '0;
                            r_alloc_rsp_fail_reason <= REASON_W'(w_alloc_reason);
                        end else begin
                            r_alloc_rsp_fail        <= 1'b0;
                            r_alloc_rsp_page_idx    <= w_alloc_base[PAGE_IDX_W-1:0];
                            r_alloc_rsp_fail_reason <= '0;
                            r_alloc_ptr <= (w_alloc_end == TOTAL_EXT) ? '0 : w_alloc_end[CNT_W-1:0];
                            r_used      <= r_used + CNT_W'(w_size);
                        end
                    end else begin
                        r_free_rsp_write_en <= 1'b1;
                        r_free_rsp_id       <= free_req_id;
                        if (w_free_reason != REASON_NONE) begin
                            r_free_rsp_fail        <= 1'b1;
                            r_free_rsp_fail_reason <= REASON_W'(w_free_reason);
                        end else begin
                            r_free_rsp_fail        <= 1'b0;
                            r_free_rsp_fail_reason <= '0;
                            r_used                 <= r_used - CNT_W'(w_size);
                        end
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alloc_req_pop         = r_alloc_req_pop;
    assign free_req_pop          = r_free_req_pop;
    assign alloc_rsp_write_en    = r_alloc_rsp_write_en;
    assign alloc_rsp_id          = r_alloc_rsp_id;
    assign alloc_rsp_page_idx    = r_alloc_rsp_page_idx;
    assign alloc_rsp_fail        = r_alloc_rsp_fail;
    assign alloc_rsp_fail_reason = r_alloc_rsp_fail_reason;
    assign free_rsp_write_en     = r_free_rsp_write_en;
    assign free_rsp_id           = r_free_rsp_id;
    assign free_rsp_fail         = r_free_rsp_fail;
    assign free_rsp_fail_reason  = r_free_rsp_fail_reason;
    assign used_page_count       = r_used;
    assign busy                  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mmu_dummy_responder.sv
// Directed bench for mmu_dummy_responder: hand-computed responses for alloc,
// free, arbitration, out-of-memory, wrap, back-pressure and mid-op reset.
module tb_mmu_dummy_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_req_fifo_empty;
    logic        alloc_req_pop;
    logic [12:0] alloc_req_id;
    logic [3:0]  alloc_req_page_count;
    logic        free_req_fifo_empty;
    logic        free_req_pop;
    logic [12:0] free_req_id;
    logic [14:0] free_req_page_idx;
    logic [3:0]  free_req_page_count;
    logic        alloc_rsp_fifo_full;
    logic        alloc_rsp_write_en;
    logic [12:0] alloc_rsp_id;
    logic [14:0] alloc_rsp_page_idx;
    logic        alloc_rsp_fail;
    logic [2:0]  alloc_rsp_fail_reason;
    logic        free_rsp_fifo_full;
    logic        free_rsp_write_en;
    logic [12:0] free_rsp_id;
    logic        free_rsp_fail;
    logic [2:0]  free_rsp_fail_reason;
    logic [15:0] used_page_count;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [12:0] rsp_id;
    logic [14:0] rsp_idx;
    logic        rsp_fail;
    logic [2:0]  rsp_reason;
    int          rsp_lat;

    mmu_dummy_responder dut (
        .clk                   (clk),
        .rst                   (rst),
        .alloc_req_fifo_empty  (alloc_req_fifo_empty),
        .alloc_req_pop         (alloc_req_pop),
        .alloc_req_id          (alloc_req_id),
        .alloc_req_page_count  (alloc_req_page_count),
        .free_req_fifo_empty   (free_req_fifo_empty),
        .free_req_pop          (free_req_pop),
        .free_req_id           (free_req_id),
        .free_req_page_idx     (free_req_page_idx),
        .free_req_page_count   (free_req_page_count),
        .alloc_rsp_fifo_full   (alloc_rsp_fifo_full),
        .alloc_rsp_write_en    (alloc_rsp_write_en),
        .alloc_rsp_id          (alloc_rsp_id),
        .alloc_rsp_page_idx    (alloc_rsp_page_idx),
        .alloc_rsp_fail        (alloc_rsp_fail),
        .alloc_rsp_fail_reason (alloc_rsp_fail_reason),
        .free_rsp_fifo_full    (free_rsp_fifo_full),
        .free_rsp_write_en     (free_rsp_write_en),
        .free_rsp_id           (free_rsp_id),
        .free_rsp_fail         (free_rsp_fail),
        .free_rsp_fail_reason  (free_rsp_fail_reason),
        .used_page_count       (used_page_count),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                  = 1'b1;
        alloc_req_fifo_empty = 1'b1;
        free_req_fifo_empty  = 1'b1;
        alloc_rsp_fifo_full  = 1'b0;
        free_rsp_fifo_full   = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Present one request, wait for its pop and its response (both bounded).
    task automatic do_req(input logic is_free, input logic [12:0] id,
                          input logic [14:0] idx, input logic [3:0] cnt);
        logic got_pop = 1'b0;
        logic got_rsp = 1'b0;
        if (is_free) begin
            free_req_id = id; free_req_page_idx = idx; free_req_page_count = cnt;
            free_req_fifo_empty = 1'b0;
        end else begin
            alloc_req_id = id; alloc_req_page_count = cnt;
            alloc_req_fifo_empty = 1'b0;
        end
        for (int i = 0; i < 20 && !got_pop; i++) begin
            tick();
            if (is_free ? free_req_pop : alloc_req_pop) begin
                got_pop = 1'b1;
                alloc_req_fifo_empty = 1'b1;
                free_req_fifo_empty  = 1'b1;
            end
        end
        rsp_lat = 0;
        for (int i = 0; i < 20 && got_pop && !got_rsp; i++) begin
            tick();
            rsp_lat++;
            if (is_free && free_rsp_write_en) begin
                got_rsp = 1'b1;
                rsp_id = free_rsp_id; rsp_idx = '0;
                rsp_fail = free_rsp_fail; rsp_reason = free_rsp_fail_reason;
            end else if (!is_free && alloc_rsp_write_en) begin
                got_rsp = 1'b1;
                rsp_id = alloc_rsp_id; rsp_idx = alloc_rsp_page_idx;
                rsp_fail = alloc_rsp_fail; rsp_reason = alloc_rsp_fail_reason;
            end
        end
        check("req_handshake", 32'({got_pop, got_rsp}), 32'h3);
    endtask

    initial begin
        int n_pops;
        int order [4];
        int cnt_a, cnt_f, cnt_w;
        logic [2:0] last_reason;

        alloc_req_id = '0; alloc_req_page_count = '0;
        free_req_id = '0; free_req_page_idx = '0; free_req_page_count = '0;
        do_reset();

        // Reset state
        check("rst_used", 32'(used_page_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pops", 32'({alloc_req_pop, free_req_pop}), 0);
        check("rst_wens", 32'({alloc_rsp_write_en, free_rsp_write_en}), 0);
        check("rst_rsp_fields", 32'({alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail}), 0);

        // Alloc 3 rounds to 4 at idx 0; response two cycles after pop
        do_req(1'b0, 13'h10, '0, 4'd3);
        check("a3_latency", 32'(rsp_lat), 2);
        check("a3_id", 32'(rsp_id), 32'h10);
        check("a3_idx", 32'(rsp_idx), 0);
        check("a3_fail", 32'(rsp_fail), 0);
        check("a3_used", 32'(used_page_count), 4);

        // Alloc 1 then 8: alignment pushes the 8-page block to idx 8, ptr 16
        do_reset();
        do_req(1'b0, 13'd1, '0, 4'd1);
        check("a1_idx", 32'(rsp_idx), 0);
        do_req(1'b0, 13'd2, '0, 4'd8);
        check("a8_idx", 32'(rsp_idx), 8);
        check("a8_used", 32'(used_page_count), 9);
        do_req(1'b0, 13'd3, '0, 4'd1);
        check("a1_after_ptr16_idx", 32'(rsp_idx), 16);
        check("used_10", 32'(used_page_count), 10);

        // Free error paths, in priority order
        do_req(1'b1, 13'h40, 15'd6, 4'd4);
        check("free_misaligned", 32'({rsp_fail, rsp_reason}), 32'({1'b1, 3'd4}));
        check("free_misaligned_id", 32'(rsp_id), 32'h40);
        do_req(1'b1, 13'h41, 15'd32766, 4'd4);
        check("free_idx_range", 32'({rsp_fail, rsp_reason}), 32'({1'b1, 3'd3}));
        do_req(1'b1, 13'h42, 15'd0, 4'd0);
        check("free_size0", 32'({rsp_fail, rsp_reason}), 32'({1'b1, 3'd1}));
        do_req(1'b1, 13'h43, 15'd0, 4'd9);
        check("free_size9", 32'({rsp_fail, rsp_reason}), 32'({1'b1, 3'd1}));
        do_req(1'b0, 13'h44, '0, 4'd0);
        check("alloc_size0", 32'({rsp_fail, rsp_reason, rsp_idx}), 32'({1'b1, 3'd1, 15'd0}));
        check("used_after_errors", 32'(used_page_count), 10);

        // Successful frees down to zero, then underflow
        do_req(1'b1, 13'h50, 15'd8, 4'd8);
        check("free8_ok", 32'({rsp_fail, rsp_reason}), 0);
        check("free8_used", 32'(used_page_count), 2);
        do_req(1'b1, 13'h51, 15'd0, 4'd1);
        do_req(1'b1, 13'h52, 15'd16, 4'd1);
        check("free_to_zero", 32'(used_page_count), 0);
        do_req(1'b1, 13'h53, 15'd0, 4'd2);
        check("free_underflow", 32'({rsp_fail, rsp_reason}), 32'({1'b1, 3'd5}));

        // Both FIFOs non-empty from reset: alloc, free, alloc, free
        do_reset();
        alloc_req_id = 13'h20; alloc_req_page_count = 4'd2;
        free_req_id  = 13'h30; free_req_page_idx = 15'd0; free_req_page_count = 4'd1;
        alloc_req_fifo_empty = 1'b0;
        free_req_fifo_empty  = 1'b0;
        n_pops = 0;
        for (int i = 0; i < 40 && n_pops < 4; i++) begin
            tick();
            if (alloc_req_pop) begin order[n_pops] = 0; n_pops++; end
            else if (free_req_pop) begin order[n_pops] = 1; n_pops++; end
        end
        alloc_req_fifo_empty = 1'b1;
        free_req_fifo_empty  = 1'b1;
        check("rr_npops", 32'(n_pops), 4);
        check("rr_0_alloc", 32'(order[0]), 0);
        check("rr_1_free", 32'(order[1]), 1);
        check("rr_2_alloc", 32'(order[2]), 0);
        check("rr_3_free", 32'(order[3]), 1);
        repeat (6) tick();
        check("rr_used", 32'(used_page_count), 2);
        check("rr_idle", 32'(busy), 0);

        // Fill to TOTAL-4, then out of memory, then wrap
        do_reset();
        for (int i = 0; i < 4095; i++) do_req(1'b0, 13'(i), '0, 4'd8);
        check("fill_used", 32'(used_page_count), 32760);
        do_req(1'b0, 13'h100, '0, 4'd3);
        check("fill_a4_idx", 32'(rsp_idx), 32760);
        check("fill_used_m4", 32'(used_page_count), 32764);
        do_req(1'b0, 13'h101, '0, 4'd8);
        check("no_mem", 32'({rsp_fail, rsp_reason, rsp_idx}), 32'({1'b1, 3'd2, 15'd0}));
        check("no_mem_used", 32'(used_page_count), 32764);
        do_req(1'b1, 13'h102, 15'd0, 4'd8);
        check("free_for_wrap", 32'(used_page_count), 32756);
        do_req(1'b0, 13'h103, '0, 4'd5);
        check("wrap_idx", 32'({rsp_fail, rsp_idx}), 0);
        check("wrap_id", 32'(rsp_id), 32'h103);
        do_req(1'b0, 13'h104, '0, 4'd4);
        check("after_wrap_idx", 32'(rsp_idx), 8);
        check("used_full", 32'(used_page_count), 32768);
        do_req(1'b0, 13'h105, '0, 4'd1);
        check("full_no_mem", 32'({rsp_fail, rsp_reason}), 32'({1'b1, 3'd2}));

        // Alloc response FIFO full: only frees are served
        do_reset();
        alloc_rsp_fifo_full = 1'b1;
        alloc_req_id = 13'd5; alloc_req_page_count = 4'd1;
        free_req_id  = 13'h31; free_req_page_idx = 15'd0; free_req_page_count = 4'd1;
        alloc_req_fifo_empty = 1'b0;
        free_req_fifo_empty  = 1'b0;
        cnt_a = 0; cnt_f = 0; cnt_w = 0; last_reason = '0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (alloc_req_pop) cnt_a++;
            if (free_req_pop) cnt_f++;
            if (free_rsp_write_en) begin cnt_w++; last_reason = free_rsp_fail_reason; end
        end
        check("afull_no_alloc_pop", 32'(cnt_a), 0);
        check("afull_free_pops", 32'(cnt_f), 5);
        check("afull_free_rsps", 32'(cnt_w), 5);
        check("afull_free_reason", 32'(last_reason), 5);

        // Both response FIFOs full: no pops at all
        free_rsp_fifo_full = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (alloc_req_pop || free_req_pop) cnt_a++;
        end
        check("both_full_no_pop", 32'(cnt_a), 0);
        check("both_full_idle", 32'(busy), 0);

        // Reset during LATCH drops the request
        do_reset();
        alloc_req_id = 13'd7; alloc_req_page_count = 4'd8;
        alloc_req_fifo_empty = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 10 && cnt_a == 0; i++) begin
            tick();
            if (alloc_req_pop) cnt_a++;
        end
        check("latch_pop_seen", 32'(cnt_a), 1);
        check("latch_busy", 32'(busy), 1);
        rst = 1'b1;
        alloc_req_fifo_empty = 1'b1;
        tick();
        check("midrst_used", 32'(used_page_count), 0);
        check("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        cnt_w = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (alloc_rsp_write_en || free_rsp_write_en) cnt_w++;
        end
        check("midrst_no_wen", 32'(cnt_w), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
